sys_bridge: RTL

SYS_BRIDGE -- requirements
Module: sys_bridge

---
 rtl/bridge_pkg.sv | 21 ++
 rtl/bridge_addr_decode.sv | 33 +++
 rtl/sys_bridge.sv | 136 +++++++++++++
 3 files changed

// File: rtl/bridge_pkg.sv
// Shared constants for the CPU-to-peripheral bridge: FSM state encoding and
// the default address windows of the data memory and the two timers.
package bridge_pkg;

  // Bridge FSM state encoding (2-bit)
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;
  localparam logic [1:0] ST_ERR  = 2'd3;

  // Data memory: 16 KiB window at 0x0000_0000
  localparam logic [31:0] DM_BASE   = 32'h0000_0000;
  localparam logic [31:0] DM_MASK   = 32'hFFFF_C000;
  // Timer 0: 16-byte register block at 0x0000_7F00
  localparam logic [31:0] TMR0_BASE = 32'h0000_7F00;
  localparam logic [31:0] TMR0_MASK = 32'hFFFF_FFF0;
  // Timer 1: 16-byte register block at 0x0000_7F10
  localparam logic [31:0] TMR1_BASE = 32'h0000_7F10;
  localparam logic [31:0] TMR1_MASK = 32'hFFFF_FFF0;

endpackage

// File: rtl/bridge_addr_decode.sv
// Combinational address decoder: per-device hit vector plus the index of
// the lowest-numbered device that hits. hit=0 means the address is unmapped.
module bridge_addr_decode import bridge_pkg::*; #(
  parameter int                 NDEV     = 3,
  parameter logic [NDEV*32-1:0] DEV_BASE = {TMR1_BASE, TMR0_BASE, DM_BASE},
  parameter logic [NDEV*32-1:0] DEV_MASK = {TMR1_MASK, TMR0_MASK, DM_MASK},
  parameter int                 IDX_W    = (NDEV > 1) ? $clog2(NDEV) : 1
) (
  input  logic [31:0]      addr,
  output logic             hit,
  output logic [IDX_W-1:0] idx
);

  logic [NDEV-1:0] hit_vec;

  // Compare the masked address against every device window
  always_comb begin
    hit_vec = '0;
    for (int i = 0; i < NDEV; i++) begin
      hit_vec[i] = ((addr & DEV_MASK[i*32 +: 32]) == DEV_BASE[i*32 +: 32]);
    end
  end

  // Priority pick: scanning downwards leaves the lowest hitting index
  always_comb begin
    hit = |hit_vec;
    idx = '0;
    for (int i = NDEV - 1; i >= 0; i--) begin
      if (hit_vec[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/sys_bridge.sv
// CPU-to-peripheral bridge. Decodes a CPU access onto one of NDEV slave
// devices, holds the device select until the device acks, then returns one
// completion pulse to the CPU. Unmapped accesses complete with cpu_err.
// Optional macro BRIDGE_TIMEOUT_EN adds an 8-bit wait-state limit: a device
// that has not acked after TO_CYCLES wait cycles turns the access into an
// error completion.
//
// Handshake: the CPU raises cpu_req with stable we/addr/wdata/be and holds it
// until cpu_ready; cpu_ready is a single-cycle pulse and cpu_rdata/cpu_err are
// valid only in that cycle. A request is accepted only in IDLE, so a request
// still high during the completion cycle is not taken as a new access. On the
// device side dev_sel stays asserted until the selected device returns
// dev_ack for one sampled cycle; acks from other devices are ignored.
module sys_bridge import bridge_pkg::*; #(
  parameter int                 NDEV      = 3,
  parameter logic [NDEV*32-1:0] DEV_BASE  = {TMR1_BASE, TMR0_BASE, DM_BASE},
  parameter logic [NDEV*32-1:0] DEV_MASK  = {TMR1_MASK, TMR0_MASK, DM_MASK},
  parameter int                 TO_CYCLES = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cpu_req,
  input  logic               cpu_we,
  input  logic [31:0]        cpu_addr,
  input  logic [31:0]        cpu_wdata,
  input  logic [3:0]         cpu_be,
  output logic [31:0]        cpu_rdata,
  output logic               cpu_ready,
  output logic               cpu_err,
  output logic [NDEV-1:0]    dev_sel,
  output logic               dev_we,
  output logic [31:0]        dev_addr,
  output logic [31:0]        dev_wdata,
  output logic [3:0]         dev_be,
  input  logic [NDEV*32-1:0] dev_rdata,
  input  logic [NDEV-1:0]    dev_ack
);

  localparam int IDX_W = (NDEV > 1) ? $clog2(NDEV) : 1;

  logic [1:0]       state;
  logic             we_q;
  logic [IDX_W-1:0] idx_q;
  logic [31:0]      rdata_q;
  logic             dec_hit;
  logic [IDX_W-1:0] dec_idx;
  logic             ack_sel;
  logic [31:0]      rdata_sel;
  logic             to_hit;

  bridge_addr_decode #(
    .NDEV     (NDEV),
    .DEV_BASE (DEV_BASE),
    .DEV_MASK (DEV_MASK),
    .IDX_W    (IDX_W)
  ) u_decode (
    .addr (cpu_addr),
    .hit  (dec_hit),
    .idx  (dec_idx)
  );

  // Only the latched device's ack and read slice are ever looked at
  assign ack_sel   = dev_ack[idx_q];
  assign rdata_sel = dev_rdata[32*idx_q +: 32];

`ifdef BRIDGE_TIMEOUT_EN
  logic [7:0] wait_cnt;

  // Wait-state counter: cleared while idle (the only way into WAIT),
  // counts every WAIT cycle that ends without an ack
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= 8'd0;
    end else if (state == ST_IDLE) begin
      wait_cnt <= 8'd0;
    end else if (state == ST_WAIT && !ack_sel) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end

  assign to_hit = ((wait_cnt + 8'd1) == 8'(TO_CYCLES));
`else
  assign to_hit = 1'b0;
`endif

  // Bridge FSM plus the request latches and the read-data holding register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      we_q      <= 1'b0;
      idx_q     <= '0;
      dev_addr  <= 32'd0;
      dev_wdata <= 32'd0;
      dev_be    <= 4'd0;
      rdata_q   <= 32'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cpu_req) begin
            we_q      <= cpu_we;
            idx_q     <= dec_idx;
            dev_addr  <= cpu_addr;
            dev_wdata <= cpu_wdata;
            dev_be    <= cpu_be;
            if (dec_hit) begin
              state <= ST_WAIT;
            end else begin
              state   <= ST_ERR;
              rdata_q <= 32'd0;
            end
          end
        end
        ST_WAIT: begin
          // An ack in the same cycle as the limit takes priority
          if (ack_sel) begin
            if (!we_q) rdata_q <= rdata_sel;
            state <= ST_RESP;
          end else if (to_hit) begin
            rdata_q <= 32'd0;
            state   <= ST_ERR;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign cpu_ready = (state == ST_RESP) || (state == ST_ERR);
  assign cpu_err   = (state == ST_ERR);
  assign cpu_rdata = rdata_q;
  assign dev_sel   = (state == ST_WAIT) ? (NDEV'(1) << idx_q) : '0;
  assign dev_we    = (state == ST_WAIT) && we_q;

endmodule
